id_ex_pipe: RTL
===============

Name: id_ex_pipe

Overview:
- Pipeline register between the ID stage (register file and control unit outputs) and the EX stage (ALU).
- Captures decoded control, operands, immediate and PC each cycle.
- Detects load-use hazards and inserts bubbles; flushes on taken branch; holds under EX backpressure.
- Applies write-back bypass so operands are never stale, and keeps a saturating stall counter for performance checks.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_uses_rs2  input  1  instruction reads rs2 (R/S/B types)
id_rd  input  5  destination register index
id_read_data1  input  XLEN  register file read port 1
id_read_data2  input  XLEN  register file read port 2
id_imm  input  XLEN  sign-extended immediate
id_reg_write  input  1  control: write register file
id_mem_write  input  1  control: store
id_mem_read  input  1  control: load
id_alu_op  input  3  control: ALU operation
ex_ready  input  1  EX accepts the held instruction this cycle
flush  input  1  taken branch/jump redirect; kill younger instructions
wb_reg_write  input  1  write-back stage writes register file this cycle
wb_rd  input  5  write-back destination
wb_data  input  XLEN  write-back value
id_stall  output  1  combinational; ID (and IF) must hold their instruction
ex_valid  output  1  EX register holds a real instruction
ex_pc  output  XLEN  registered PC
ex_rs1, ex_rs2, ex_rd  output  5 each  registered register indices
ex_op_a, ex_op_b  output  XLEN  registered operands (post-bypass)
ex_imm  output  XLEN  registered immediate
ex_reg_write, ex_mem_write, ex_mem_read  output  1 each  registered controls
ex_alu_op  output  3  registered ALU op
stall_count  output  STALL_CNT_W  cycles with id_stall=1, saturating

Behaviour:
- Reset (reset==0 at posedge clk): every registered output is 0, including ex_valid, all controls, data fields and stall_count. Reset asserted mid-operation discards the held instruction. id_stall is 0 while reset==0.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- id_stall = reset & ~flush & (~ex_ready | load_use).
- Per-edge priority (first match wins):
  1. reset low: clear.
  2. flush: ex_valid<=0 and all four controls<=0; data fields don't-care (hold).
  3. ~ex_ready: hold every field. Held-operand bypass still applies: if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1, ex_op_a<=wb_data. Same rule for ex_rs2/ex_op_b.
  4. load_use: bubble. ex_valid<=0, controls<=0. ID holds because id_stall=1. The same ID instruction is captured next cycle.
  5. Otherwise capture:
     - ex_valid<=id_valid. All controls are ANDed with id_valid.
     - ex_reg_write<=id_reg_write & id_valid & (id_rd!=0).
     - ex_op_a<=(wb_reg_write & wb_rd!=0 & wb_rd==id_rs1) ? wb_data : id_read_data1. ex_op_b likewise with id_rs2.
- Latency: one cycle from ID to EX outputs when there is no stall.
- Simultaneous flush+load_use or flush+~ex_ready: flush wins, id_stall=0.
- stall_count: +1 on each posedge where reset==1 and id_stall==1. Saturates at all-ones with no wrap.
- Register x0: never a hazard source and never bypassed.

Decomposition:
- Shared package riscv_pipe_pkg: XLEN, REG_IDX_W=5, ALU_OP_W=3, ALU op encodings, and a ctrl_t struct {reg_write, mem_write, mem_read, alu_op} reused by the later EX/MEM and MEM/WB registers.
- One combinational sub-module, hazard_detect, computes load_use. It is reused when forwarding is added to EX.

Test Plan:
- Reset: drive reset=0 for 2 cycles with id_valid=1 and all controls 1 -> all outputs 0 and stall_count=0; release -> next edge captures id_pc=0x10 into ex_pc=0x10 with ex_valid=1.
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5); ID presents add x6,x5,x7 with ex_ready=1 -> id_stall=1 and one bubble (ex_valid=0); next edge captures the add; stall_count=1.
- WB bypass on capture: id_rs1=3, id_read_data1=0x11, wb_reg_write=1, wb_rd=3, wb_data=0xAA -> ex_op_a=0xAA. Repeat with wb_rd=0 -> ex_op_a=0x11.
- Backpressure: ex_ready=0 for 3 cycles, with wb writing x2=0x55 while ex_rs2=2 -> all fields held except ex_op_b=0x55; id_stall=1 each cycle; stall_count +3.
- Flush priority: flush=1 together with load_use and ex_ready=0 -> id_stall=0, next ex_valid=0 and controls 0; a destination of x0 with id_reg_write=1 -> ex_reg_write=0.
- Counter saturation: force 0x10000+ stall cycles (or STALL_CNT_W=4 with 20 stalls) -> stall_count sticks at 0xF (all-ones), no wrap.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op encodings and the
// control bundle carried by every inter-stage register.
package riscv_pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALU_OP_W  = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluOp_e;

  typedef struct packed {
    logic                regWrite;
    logic                memWrite;
    logic                memRead;
    logic [ALU_OP_W-1:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // x0 is hard-wired to zero, so a write-back to it must never be forwarded.
  function automatic logic wbHits(input logic                 wbRegWrite,
                                  input logic [REG_IDX_W-1:0] wbRd,
                                  input logic [REG_IDX_W-1:0] rs);
    return wbRegWrite && (wbRd != '0) && (wbRd == rs);
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard: the instruction in EX is a load whose result the
// instruction in ID needs before it is available.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic                 exValid,
  input  logic                 exMemRead,
  input  logic [REG_IDX_W-1:0] exRd,
  input  logic                 idValid,
  input  logic [REG_IDX_W-1:0] idRs1,
  input  logic [REG_IDX_W-1:0] idRs2,
  input  logic                 idUsesRs2,
  output logic                 loadUse
);

  assign loadUse = exValid & exMemRead & (exRd != '0) & idValid &
                   ((exRd == idRs1) | (idUsesRs2 & (exRd == idRs2)));

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubbling, branch flush, EX
// backpressure hold, write-back bypass and a saturating stall counter.
module id_ex_pipe #(
  parameter int XLEN        = riscv_pipe_pkg::XLEN,
  parameter int STALL_CNT_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 id_valid,
  input  logic [XLEN-1:0]                      id_pc,
  input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] id_rs1,
  input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] id_rs2,
  input  logic                                 id_uses_rs2,
  input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] id_rd,
  input  logic [XLEN-1:0]                      id_read_data1,
  input  logic [XLEN-1:0]                      id_read_data2,
  input  logic [XLEN-1:0]                      id_imm,
  input  logic                                 id_reg_write,
  input  logic                                 id_mem_write,
  input  logic                                 id_mem_read,
  input  logic [riscv_pipe_pkg::ALU_OP_W-1:0]  id_alu_op,
  input  logic                                 ex_ready,
  input  logic                                 flush,
  input  logic                                 wb_reg_write,
  input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                      wb_data,
  output logic                                 id_stall,
  output logic                                 ex_valid,
  output logic [XLEN-1:0]                      ex_pc,
  output logic [riscv_pipe_pkg::REG_IDX_W-1:0] ex_rs1,
  output logic [riscv_pipe_pkg::REG_IDX_W-1:0] ex_rs2,
  output logic [riscv_pipe_pkg::REG_IDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]                      ex_op_a,
  output logic [XLEN-1:0]                      ex_op_b,
  output logic [XLEN-1:0]                      ex_imm,
  output logic                                 ex_reg_write,
  output logic                                 ex_mem_write,
  output logic                                 ex_mem_read,
  output logic [riscv_pipe_pkg::ALU_OP_W-1:0]  ex_alu_op,
  output logic [STALL_CNT_W-1:0]               stall_count
);

  import riscv_pipe_pkg::*;

  ctrl_t exCtrl;
  ctrl_t idCtrl;
  logic  loadUse;
  logic  [STALL_CNT_W-1:0] stallCnt;

  hazard_detect uHazard (
    .exValid  (ex_valid),
    .exMemRead(exCtrl.memRead),
    .exRd     (ex_rd),
    .idValid  (id_valid),
    .idRs1    (id_rs1),
    .idRs2    (id_rs2),
    .idUsesRs2(id_uses_rs2),
    .loadUse  (loadUse)
  );

  // Flush overrides both stall causes: the ID instruction is being killed anyway.
  assign id_stall = reset & ~flush & (~ex_ready | loadUse);

  always_comb begin
    idCtrl          = CTRL_NOP;
    idCtrl.regWrite = id_valid & id_reg_write & (id_rd != '0);
    idCtrl.memWrite = id_valid & id_mem_write;
    idCtrl.memRead  = id_valid & id_mem_read;
    idCtrl.aluOp    = id_valid ? id_alu_op : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      exCtrl   <= CTRL_NOP;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_op_a  <= '0;
      ex_op_b  <= '0;
      ex_imm   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      exCtrl   <= CTRL_NOP;
    end else if (!ex_ready) begin
      // Held operands keep tracking write-back so they are not stale on release.
      if (wbHits(wb_reg_write, wb_rd, ex_rs1)) ex_op_a <= wb_data;
      if (wbHits(wb_reg_write, wb_rd, ex_rs2)) ex_op_b <= wb_data;
    end else if (loadUse) begin
      ex_valid <= 1'b0;
      exCtrl   <= CTRL_NOP;
    end else begin
      ex_valid <= id_valid;
      exCtrl   <= idCtrl;
      ex_pc    <= id_pc;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_imm   <= id_imm;
      ex_op_a  <= wbHits(wb_reg_write, wb_rd, id_rs1) ? wb_data : id_read_data1;
      ex_op_b  <= wbHits(wb_reg_write, wb_rd, id_rs2) ? wb_data : id_read_data2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (id_stall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + STALL_CNT_W'(1);
    end
  end

  assign ex_reg_write = exCtrl.regWrite;
  assign ex_mem_write = exCtrl.memWrite;
  assign ex_mem_read  = exCtrl.memRead;
  assign ex_alu_op    = exCtrl.aluOp;
  assign stall_count  = stallCnt;

endmodule
